// File: rtl/mult_seq_accum.sv
// Sequential 4x4 unsigned multiplier built from an external 2x2 multiplier
// and shifter; four partial products are accumulated into an 8-bit result.
module mult_seq_accum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [1:0] pa,
    output logic [1:0] pb,
    output logic [1:0] shctrl,
    input  logic [7:0] sh_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [3:0] xr;
    logic [3:0] yr;
    logic [7:0] acc;
    logic       carry;
    logic [8:0] sum;

    assign sum = {1'b0, acc} + {1'b0, sh_in};

    // Select operand slices and shift amount for the current step
    always_comb begin
        pa     = '0;
        pb     = '0;
        shctrl = '0;
        if (state == STEP) begin
            case (cnt)
                2'd0: begin
                    pa     = xr[1:0];
                    pb     = yr[1:0];
                    shctrl = 2'b00;
                end
                2'd1: begin
                    pa     = xr[1:0];
                    pb     = yr[3:2];
                    shctrl = 2'b01;
                end
                2'd2: begin
                    pa     = xr[3:2];
                    pb     = yr[1:0];
                    shctrl = 2'b01;
                end
                default: begin
                    pa     = xr[3:2];
                    pb     = yr[3:2];
                    shctrl = 2'b10;
                end
            endcase
        end
    end

    // Control FSM, accumulator and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            xr      <= '0;
            yr      <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= X;
                        yr    <= Y;
                        acc   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= STEP;
                    end else begin
                        state <= IDLE;
                    end
                end
                STEP: begin
                    acc   <= sum[7:0];
                    carry <= carry | sum[8];
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        product <= sum[7:0];
                        ovf     <= carry | sum[8];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_accum.sv
// Testbench for mult_seq_accum: table vectors, exhaustive sweep,
// random operations and hand-written corner sequences.
module tb_mult_seq_accum;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] X;
    logic [3:0] Y;
    logic [1:0] pa;
    logic [1:0] pb;
    logic [1:0] shctrl;
    logic [7:0] sh_in;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic       ovf;
    logic       force80;

    int n_vec;
    int n_err;

    mult_seq_accum dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .X       (X),
        .Y       (Y),
        .pa      (pa),
        .pb      (pb),
        .shctrl  (shctrl),
        .sh_in   (sh_in),
        .busy    (busy),
        .done    (done),
        .product (product),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 2x2 multiplier followed by the shifter
    always_comb begin
        int p;
        int s;
        p = int'(pa) * int'(pb);
        case (shctrl)
            2'b01:   s = 2;
            2'b10:   s = 4;
            default: s = 0;
        endcase
        sh_in = force80 ? 8'h80 : 8'((p << s) & 255);
    end

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        bit         f;
        logic [7:0] ep;
        logic       eo;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [1:0] exp_sh(input int k);
        case (k)
            0:       return 2'b00;
            3:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] x, input logic [3:0] y,
                         input bit f, input logic [7:0] ep,
                         input logic eo);
        X       = x;
        Y       = y;
        force80 = f;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        X     = ~x;
        Y     = y + 4'd5;
        for (int k = 0; k < 4; k++) begin
            chk("busy", 32'(busy), 1);
            chk("done_early", 32'(done), 0);
            chk("shctrl", 32'(shctrl), 32'(exp_sh(k)));
            @(posedge clk);
            #1;
        end
        chk("done", 32'(done), 1);
        chk("busy_off", 32'(busy), 0);
        chk("product", 32'(product), 32'(ep));
        chk("ovf", 32'(ovf), 32'(eo));
        chk("pa_idle", 32'({pa, pb, shctrl}), 0);
        @(posedge clk);
        #1;
        chk("done_clear", 32'(done), 0);
        chk("product_hold", 32'(product), 32'(ep));
        force80 = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        X       = '0;
        Y       = '0;
        force80 = 1'b0;

        tbl[0] = '{4'd15, 4'd15, 1'b0, 8'hE1, 1'b0};
        tbl[1] = '{4'd0,  4'd0,  1'b0, 8'h00, 1'b0};
        tbl[2] = '{4'd15, 4'd0,  1'b0, 8'h00, 1'b0};
        tbl[3] = '{4'd1,  4'd1,  1'b0, 8'h01, 1'b0};
        tbl[4] = '{4'd8,  4'd8,  1'b0, 8'h40, 1'b0};
        tbl[5] = '{4'd10, 4'd5,  1'b0, 8'h32, 1'b0};
        tbl[6] = '{4'd15, 4'd15, 1'b1, 8'h00, 1'b1};
        tbl[7] = '{4'd4,  4'd4,  1'b1, 8'h00, 1'b1};

        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_product", 32'(product), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_pa_pb_sh", 32'({pa, pb, shctrl}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            do_op(tbl[i].x, tbl[i].y, tbl[i].f, tbl[i].ep, tbl[i].eo);

        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                do_op(4'(xi), 4'(yi), 1'b0, 8'(xi * yi), 1'b0);

        for (int i = 0; i < 40; i++) begin
            int rx;
            int ry;
            rx = int'($urandom_range(15, 0));
            ry = int'($urandom_range(15, 0));
            do_op(4'(rx), 4'(ry), 1'b0, 8'(rx * ry), 1'b0);
        end

        // start held high: second operation accepted in DONE
        X     = 4'd3;
        Y     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_busy1", 32'(busy), 1);
            chk("b2b_nodone1", 32'(done), 0);
            @(posedge clk);
            #1;
        end
        chk("b2b_done1", 32'(done), 1);
        chk("b2b_prod1", 32'(product), 6);
        X = 4'd5;
        Y = 4'd7;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_busy2", 32'(busy), 1);
            chk("b2b_nodone2", 32'(done), 0);
            chk("b2b_hold", 32'(product), 6);
            @(posedge clk);
            #1;
        end
        chk("b2b_done2", 32'(done), 1);
        chk("b2b_prod2", 32'(product), 35);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_end", 32'(done), 0);

        // asynchronous reset in the middle of an operation
        X     = 4'd9;
        Y     = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_shctrl", 32'(shctrl), 1);
        chk("mid_busy", 32'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_product", 32'(product), 0);
        chk("arst_ovf", 32'(ovf), 0);
        chk("arst_pa_pb_sh", 32'({pa, pb, shctrl}), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("arst_nodone", 32'(done), 0);
        end
        rst_n = 1'b1;
        do_op(4'd2, 4'd3, 1'b0, 8'd6, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("post_idle_done", 32'(done), 0);
            chk("post_idle_prod", 32'(product), 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
